// File: rtl/nonoverlap_gate_driver.sv
// Break-before-make gate driver: splits one requested level into PMOS/NMOS gate drives with a DEAD_CYC both-off gap.
// Optional sticky shoot-through detector is built only when GATE_FAULT_CHK_EN is defined.
module nonoverlap_gate_driver #(
  parameter int DEAD_CYC = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in,
  output logic             pg,
  output logic             ng,
  output logic             settled,
  output logic [CNT_W-1:0] sw_cnt,
  output logic             fault
);

  localparam int DCNT_W = (DEAD_CYC < 1) ? 1 : $clog2(DEAD_CYC + 1);
  localparam logic [DCNT_W-1:0] DT_LOAD = DCNT_W'(DEAD_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_HI_ON = 2'd1,
    S_LO_ON = 2'd2,
    S_DT    = 2'd3
  } state_t;

  // {pg, ng, settled} for each state; DT and OFF both hold the two devices off.
  function automatic logic [2:0] gate_decode(input state_t s);
    logic [2:0] g;
    case (s)
      S_HI_ON: g = 3'b001;
      S_LO_ON: g = 3'b111;
      S_DT:    g = 3'b100;
      default: g = 3'b100;
    endcase
    return g;
  endfunction

  state_t              state_p0, state_p1;
  logic [DCNT_W-1:0]   dcnt_p0, dcnt_p1;
  logic                sw_inc;
  logic                pg_p1, ng_p1, settled_p1;
  logic [CNT_W-1:0]    sw_cnt_p1;
  logic                fault_now;

`ifdef GATE_FAULT_CHK_EN
  logic fault_p1;
  logic overlap;

  // Overlap on the registered gates forces OFF on the same edge it is seen.
  assign overlap   = ~pg_p1 & ng_p1;
  assign fault_now = fault_p1 | overlap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_p1 <= 1'b0;
    end else if (overlap) begin
      fault_p1 <= 1'b1;
    end
  end

  assign fault = fault_p1;
`else
  assign fault_now = 1'b0;
  assign fault     = 1'b0;
`endif

  // Stage p0: next-state decision from the current registered state
  always_comb begin
    state_p0 = state_p1;
    dcnt_p0  = dcnt_p1;
    sw_inc   = 1'b0;
    if (!en || fault_now) begin
      state_p0 = S_OFF;
      dcnt_p0  = '0;
    end else begin
      case (state_p1)
        S_OFF: begin
          state_p0 = in ? S_HI_ON : S_LO_ON;
        end
        S_HI_ON: begin
          if (!in) begin
            state_p0 = S_DT;
            dcnt_p0  = DT_LOAD;
          end
        end
        S_LO_ON: begin
          if (in) begin
            state_p0 = S_DT;
            dcnt_p0  = DT_LOAD;
          end
        end
        S_DT: begin
          if (dcnt_p1 != '0) begin
            dcnt_p0 = dcnt_p1 - DCNT_W'(1);
          end else begin
            state_p0 = in ? S_HI_ON : S_LO_ON;
            sw_inc   = 1'b1;
          end
        end
        default: begin
          state_p0 = S_OFF;
          dcnt_p0  = '0;
        end
      endcase
    end
  end

  // Stage p1: registered state, gate drives and switch count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1   <= S_OFF;
      dcnt_p1    <= '0;
      pg_p1      <= 1'b1;
      ng_p1      <= 1'b0;
      settled_p1 <= 1'b0;
      sw_cnt_p1  <= '0;
    end else begin
      state_p1                        <= state_p0;
      dcnt_p1                         <= dcnt_p0;
      {pg_p1, ng_p1, settled_p1}      <= gate_decode(state_p0);
      sw_cnt_p1                       <= sw_cnt_p1 + CNT_W'(sw_inc);
    end
  end

  assign pg      = pg_p1;
  assign ng      = ng_p1;
  assign settled = settled_p1;
  assign sw_cnt  = sw_cnt_p1;

endmodule
